fetch_unit: RTL and testbench

- Instruction-fetch stage of the multicycle CPU, directly upstream of the 4 KB instruction memory.
- Owns the fetch PC and drives the word address into the instruction memory. That memory has a registered read (dout updates on the posedge after addr is sampled).
- Captures the returned word into the instruction register (IR) for decode.
- Sequences fetches on request from the main control FSM and accepts branch/jump redirects.

---
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, drives the instruction memory
// word address and captures the returned word into the instruction register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [9:0]  im_addr,
    input  logic [31:0] im_dout,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic [31:0] ir_pc_plus4,
    output logic        ir_valid,
    output logic        busy,
    output logic        misalign_err,
    output logic [31:0] fetch_count,
    output logic [1:0]  state_dbg
);

    // Handshake: fetch_req is a level sampled only in IDLE (no queuing); ir_valid
    // rises two edges later and holds, with ir stable, until the next accepted
    // fetch_req or an aligned redirect clears it.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] ir_d, ir_pc_d, fetch_count_d;
    logic        ir_valid_d, misalign_err_d;
    logic        redirect_ok;

    assign redirect_ok = redirect_valid && (redirect_pc[1:0] == 2'b00);

    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        ir_d           = ir;
        ir_pc_d        = ir_pc;
        ir_valid_d     = ir_valid;
        fetch_count_d  = fetch_count;
        misalign_err_d = misalign_err;

        if (redirect_valid && !redirect_ok) begin
            misalign_err_d = 1'b1;
        end

        // An aligned redirect beats everything, including a capture in WAIT.
        if (redirect_ok) begin
            fetch_pc_d = redirect_pc;
            ir_valid_d = 1'b0;
            state_d    = (state_q == S_IDLE && fetch_req) ? S_REQ : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fetch_req) begin
                        state_d    = S_REQ;
                        ir_valid_d = 1'b0;
                    end
                end
                S_REQ: begin
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    ir_d          = im_dout;
                    ir_pc_d       = fetch_pc_q;
                    fetch_pc_d    = fetch_pc_q + 32'd4;
                    ir_valid_d    = 1'b1;
                    fetch_count_d = fetch_count + 32'd1;
                    state_d       = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            fetch_pc_q   <= RESET_PC;
            ir           <= 32'd0;
            ir_pc        <= 32'd0;
            ir_valid     <= 1'b0;
            misalign_err <= 1'b0;
            fetch_count  <= 32'd0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            ir           <= ir_d;
            ir_pc        <= ir_pc_d;
            ir_valid     <= ir_valid_d;
            misalign_err <= misalign_err_d;
            fetch_count  <= fetch_count_d;
        end
    end

    // Memory only sees bits [11:2], so addresses alias every 4 KB.
    assign im_addr     = fetch_pc_q[11:2];
    assign ir_pc_plus4 = ir_pc + 32'd4;
    assign busy        = (state_q == S_REQ) || (state_q == S_WAIT);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: registered-read memory model, table of
// fetch vectors, scoreboard of expected {ir, ir_pc}, and multi-cycle corner cases.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [9:0]  im_addr;
    logic [31:0] im_dout;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic [31:0] ir_pc_plus4;
    logic        ir_valid;
    logic        busy;
    logic        misalign_err;
    logic [31:0] fetch_count;
    logic [1:0]  state_dbg;

    int checks;
    int errors;

    logic [31:0] mem [1024];
    logic [63:0] exp_q[$];
    logic        iv_prev;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] exp_pc;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs [6];

    fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_req      (fetch_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .im_addr        (im_addr),
        .im_dout        (im_dout),
        .ir             (ir),
        .ir_pc          (ir_pc),
        .ir_pc_plus4    (ir_pc_plus4),
        .ir_valid       (ir_valid),
        .busy           (busy),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count),
        .state_dbg      (state_dbg)
    );

    // Clock and registered-read instruction memory
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) im_dout <= mem[im_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every rising ir_valid must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            iv_prev <= 1'b0;
        end else begin
            if (ir_valid && !iv_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got ir_pc %h expected no capture", ir_pc);
                end else begin
                    check("sb_ir", ir, exp_q[0][63:32]);
                    check("sb_ir_pc", ir_pc, exp_q[0][31:0]);
                    check("sb_ir_pc_plus4", ir_pc_plus4, exp_q[0][31:0] + 32'd4);
                    void'(exp_q.pop_front());
                end
            end
            iv_prev <= ir_valid;
        end
    end

    // One complete fetch started from IDLE, optionally with a same-edge redirect.
    task automatic do_fetch(input logic redir, input logic [31:0] rpc,
                            input logic [31:0] exp_pc, input logic [31:0] exp_cnt);
        logic [31:0] nxt;
        nxt = exp_pc + 32'd4;
        fetch_req      = 1'b1;
        redirect_valid = redir;
        redirect_pc    = rpc;
        exp_q.push_back({mem[exp_pc[11:2]], exp_pc});
        tick();
        fetch_req      = 1'b0;
        redirect_valid = 1'b0;
        check("req_busy", {31'd0, busy}, 32'd1);
        check("req_ir_valid", {31'd0, ir_valid}, 32'd0);
        tick();
        check("wait_busy", {31'd0, busy}, 32'd1);
        check("wait_ir_valid", {31'd0, ir_valid}, 32'd0);
        tick();
        check("done_ir_valid", {31'd0, ir_valid}, 32'd1);
        check("done_busy", {31'd0, busy}, 32'd0);
        check("done_count", fetch_count, exp_cnt);
        check("done_im_addr", {22'd0, im_addr}, {22'd0, nxt[11:2]});
    endtask

    initial begin
        logic [31:0] held_ir;
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        fetch_req      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'h2008_0005;

        vecs[0] = '{1'b0, 32'h0000_0000, 32'h0000_300C, 32'd4};
        vecs[1] = '{1'b1, 32'h0000_3100, 32'h0000_3100, 32'd5};
        vecs[2] = '{1'b0, 32'h0000_0000, 32'h0000_3104, 32'd6};
        vecs[3] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd7};
        vecs[4] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'd8};
        vecs[5] = '{1'b1, 32'h0000_5ABC, 32'h0000_5ABC, 32'd9};

        // Reset state
        repeat (2) tick();
        check("rst_ir", ir, 32'd0);
        check("rst_ir_pc", ir_pc, 32'd0);
        check("rst_ir_pc_plus4", ir_pc_plus4, 32'd4);
        check("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_misalign", {31'd0, misalign_err}, 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_im_addr", {22'd0, im_addr}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // fetch_req held high: one instruction per 3 cycles, extra requests ignored
        fetch_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            logic [31:0] pc;
            pc = 32'h0000_3000 + 32'(4 * k);
            exp_q.push_back({mem[pc[11:2]], pc});
            tick();
            check("held_req_busy", {31'd0, busy}, 32'd1);
            check("held_req_ir_valid", {31'd0, ir_valid}, 32'd0);
            tick();
            check("held_wait_state", {30'd0, state_dbg}, 32'd2);
            tick();
            check("held_ir_valid", {31'd0, ir_valid}, 32'd1);
            check("held_count", fetch_count, 32'(k + 1));
            if (k == 0) begin
                check("first_ir", ir, 32'h2008_0005);
                check("first_ir_pc", ir_pc, 32'h0000_3000);
                check("first_ir_pc_plus4", ir_pc_plus4, 32'h0000_3004);
                check("first_im_addr", {22'd0, im_addr}, 32'h0000_0001);
            end
        end
        fetch_req = 1'b0;

        // Table-driven fetches with random idle gaps in between
        for (int v = 0; v < 6; v++) begin
            do_fetch(vecs[v].redir, vecs[v].rpc, vecs[v].exp_pc, vecs[v].exp_cnt);
            held_ir = ir;
            repeat ($urandom_range(0, 2)) begin
                tick();
                check("gap_ir_valid", {31'd0, ir_valid}, 32'd1);
                check("gap_ir_hold", ir, held_ir);
            end
        end

        // Redirect during WAIT aborts the in-flight fetch
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        check("abort_in_wait", {30'd0, state_dbg}, 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3040;
        tick();
        redirect_valid = 1'b0;
        check("abort_ir_valid", {31'd0, ir_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_state", {30'd0, state_dbg}, 32'd0);
        check("abort_count", fetch_count, 32'd9);
        check("abort_ir_pc", ir_pc, 32'h0000_5ABC);
        check("abort_ir", ir, mem[10'h2AF]);
        check("abort_im_addr", {22'd0, im_addr}, 32'h0000_0010);
        do_fetch(1'b0, 32'd0, 32'h0000_3040, 32'd10);

        // Aligned redirect in IDLE without a request clears ir_valid
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3200;
        tick();
        redirect_valid = 1'b0;
        check("idle_redir_ir_valid", {31'd0, ir_valid}, 32'd0);
        check("idle_redir_busy", {31'd0, busy}, 32'd0);
        check("idle_redir_im_addr", {22'd0, im_addr}, 32'h0000_0080);

        // Misaligned redirect with fetch_req: ignored, fetch proceeds, flag sticks
        do_fetch(1'b1, 32'h0000_3002, 32'h0000_3200, 32'd11);
        check("misalign_set", {31'd0, misalign_err}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3201;
        tick();
        redirect_valid = 1'b0;
        check("misalign_ir_valid_kept", {31'd0, ir_valid}, 32'd1);
        check("misalign_pc_kept", {22'd0, im_addr}, 32'h0000_0081);
        check("misalign_idle", {31'd0, busy}, 32'd0);
        repeat (3) tick();
        check("misalign_sticky", {31'd0, misalign_err}, 32'd1);

        // Asynchronous reset in REQ: immediate reset values, no capture afterwards
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_ir", ir, 32'd0);
        check("arst_ir_pc", ir_pc, 32'd0);
        check("arst_ir_valid", {31'd0, ir_valid}, 32'd0);
        check("arst_misalign", {31'd0, misalign_err}, 32'd0);
        check("arst_count", fetch_count, 32'd0);
        check("arst_im_addr", {22'd0, im_addr}, 32'd0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_ir_valid", {31'd0, ir_valid}, 32'd0);
        check("post_rst_count", fetch_count, 32'd0);
        check("post_rst_ir", ir, 32'd0);
        do_fetch(1'b0, 32'd0, 32'h0000_3000, 32'd1);

        tick();
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
